collatz_host: RTL

Host-side initiator for the Collatz compute tile's byte-wide pin protocol. It accepts a 32-bit start value over a valid/ready request port and writes it into the tile. It then starts the computation, waits for completion, reads back the orbit length and path record, and returns them on a valid/ready response port. It sits between an on-chip command source (or FPGA test harness) and the tile's ui/uo/uio pins.

---
 rtl/collatz_pkg.sv | 35 +++
 rtl/collatz_host_timer.sv | 34 +++
 rtl/collatz_host.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// collatz_pkg: shared definitions for the Collatz tile host initiator.
//   host_state_t   - host FSM state encoding
//   *_STROBE/SEL_* - bit masks on the tile uio input pins
//   *_BYTES        - byte counts of the orbit and path-record read fields
//   OVERFLOW_MAGIC - record value the tile uses to flag overflow
//   read_addr()    - uio read address for the n-th byte of the read phase
package collatz_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_START,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_READ_ADDR,
      S_READ_SAMPLE,
      S_RESP
   } host_state_t;

   localparam logic [7:0]  WR_STROBE      = 8'h80;
   localparam logic [7:0]  START_STROBE   = 8'h40;
   localparam logic [7:0]  SEL_RECORD     = 8'h10;
   localparam int unsigned ORBIT_BYTES    = 2;
   localparam int unsigned RECORD_BYTES   = 4;
   localparam logic [31:0] OVERFLOW_MAGIC = 32'hBAADF00D;

   // Orbit bytes live at 0x00.., record bytes at SEL_RECORD|0x00..
   function automatic logic [7:0] read_addr(input logic [2:0] idx);
      if (idx < 3'(ORBIT_BYTES))
         read_addr = {5'b0, idx};
      else
         read_addr = SEL_RECORD | {5'b0, idx - 3'(ORBIT_BYTES)};
   endfunction

endpackage

// File: rtl/collatz_host_timer.sv
// collatz_host_timer: saturating timeout counter for the host wait phases.
//   clk, reset - clock, synchronous active-high reset
//   clear      - reload the count to zero
//   enable     - count this cycle
//   expired    - high during the TIMEOUT_CYCLES-th enabled cycle since clear,
//                so the owner leaves exactly TIMEOUT_CYCLES cycles after clear
module collatz_host_timer
   import collatz_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable && count != MAX)
         count <= count + CW'(1);
   end

   assign expired = enable && (count >= LAST);

endmodule

// File: rtl/collatz_host.sv
// collatz_host: host initiator for the Collatz tile byte-wide pin protocol.
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake; req_start is the 32-bit start value
//   resp_valid/ready    - response handshake; resp_orbit, resp_record,
//                         resp_overflow (record == magic), resp_timeout
//   dut_ui, dut_uio     - driven tile pins (data, strobes/address)
//   dut_uo, dut_uio_oe  - tile data output and output-enable (oe[7] = busy)
// All outputs are registered; each transition loads the pin values of the
// state being entered, so pins always match the current state.
module collatz_host
   import collatz_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_start,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_orbit,
   output logic [31:0] resp_record,
   output logic        resp_overflow,
   output logic        resp_timeout,
   output logic [7:0]  dut_ui,
   output logic [7:0]  dut_uio,
   input  logic [7:0]  dut_uo,
   input  logic [7:0]  dut_uio_oe
);

   host_state_t state;
   logic [1:0]  wr_idx;
   logic [2:0]  rd_idx;
   logic [31:0] wr_data;
   logic [47:0] rd_data;
   logic        timed_out;
   logic        timer_clear;
   logic        timer_en;
   logic        timer_expired;
   logic        unused_oe;

   assign unused_oe   = ^dut_uio_oe[6:0];
   assign timer_clear = (state == S_START);
   assign timer_en    = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);

   collatz_host_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         req_ready     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_orbit    <= '0;
         resp_record   <= '0;
         resp_overflow <= 1'b0;
         resp_timeout  <= 1'b0;
         dut_ui        <= '0;
         dut_uio       <= '0;
         wr_idx        <= '0;
         rd_idx        <= '0;
         wr_data       <= '0;
         rd_data       <= '0;
         timed_out     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  dut_ui    <= req_start[7:0];
                  wr_data   <= {8'h00, req_start[31:8]};
                  dut_uio   <= WR_STROBE;
                  wr_idx    <= '0;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (wr_idx == 2'd3) begin
                  dut_ui  <= '0;
                  dut_uio <= START_STROBE;
                  state   <= S_START;
               end else begin
                  wr_idx  <= wr_idx + 2'd1;
                  dut_ui  <= wr_data[7:0];
                  wr_data <= {8'h00, wr_data[31:8]};
                  dut_uio <= WR_STROBE | {6'b0, wr_idx + 2'd1};
               end
            end
            S_START: begin
               dut_uio   <= '0;
               timed_out <= 1'b0;
               state     <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (timer_expired) begin
                  timed_out <= 1'b1;
                  rd_data   <= '0;
                  state     <= S_RESP;
               end else if (dut_uio_oe[7]) begin
                  state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (timer_expired) begin
                  timed_out <= 1'b1;
                  rd_data   <= '0;
                  state     <= S_RESP;
               end else if (!dut_uio_oe[7]) begin
                  rd_idx  <= '0;
                  dut_uio <= read_addr(3'd0);
                  state   <= S_READ_ADDR;
               end
            end
            S_READ_ADDR: begin
               state <= S_READ_SAMPLE;
            end
            S_READ_SAMPLE: begin
               // Bytes arrive LSB first: after six shifts [15:0] is the orbit
               // and [47:16] the record.
               rd_data <= {dut_uo, rd_data[47:8]};
               if (rd_idx == 3'(ORBIT_BYTES + RECORD_BYTES - 1)) begin
                  dut_uio <= '0;
                  state   <= S_RESP;
               end else begin
                  rd_idx  <= rd_idx + 3'd1;
                  dut_uio <= read_addr(rd_idx + 3'd1);
                  state   <= S_READ_ADDR;
               end
            end
            S_RESP: begin
               if (!resp_valid) begin
                  resp_valid    <= 1'b1;
                  resp_orbit    <= rd_data[15:0];
                  resp_record   <= rd_data[47:16];
                  resp_overflow <= (rd_data[47:16] == OVERFLOW_MAGIC);
                  resp_timeout  <= timed_out;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
